// File: rtl/comperator_block_row_reader.sv
// Block row reader: packs up to BLOCK_SIZE AXI4-Stream pixels per go
// into one flat register, padding short (tlast-terminated) blocks.
//
// Ports:
//   aclk, aresetn        clock, async active-low reset
//   s_axis_t*            AXI4-Stream pixel input (tuser = SOF, tlast = EOL)
//   go                   start one block read (IDLE/DONE only)
//   done                 level, block complete until next go
//   block                packed pixels, first pixel in MSB slice
//   valid_count          real (non-pad) pixels in block
//   sof, eol             SOF on first beat / EOL on last beat
//   sync_drops           beats discarded waiting for SOF
//                        (only with BLOCK_READER_SOF_SYNC_EN)
//
// Optional: define BLOCK_READER_SOF_SYNC_EN to drop beats before the
// first tuser=1 beat of a block.
module comperator_block_row_reader #(
  parameter int DATA_WIDTH = 24,
  parameter int BLOCK_SIZE = 8,
  parameter int PAD_MODE   = 0,
  parameter int CNT_W      = $clog2(BLOCK_SIZE + 1)
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic                             s_axis_tuser,
  input  logic                             go,
  output logic                             done,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] block,
  output logic [CNT_W-1:0]                 valid_count,
  output logic                             sof,
  output logic                             eol
`ifdef BLOCK_READER_SOF_SYNC_EN
  ,
  output logic [15:0]                      sync_drops
`endif
);

  localparam int BW = BLOCK_SIZE * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    PAD,
    DONE
  } state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   blk_q, blk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // total words in the block (real + pad); drives the PAD exit
  logic [CNT_W-1:0] fill_q, fill_d;
  logic            sof_q, sof_d;
  logic            eol_q, eol_d;
  logic            accept;
  logic            drop;
  logic            pack;
  logic            start;
  logic [DATA_WIDTH-1:0] pad_word;

  assign s_axis_tready = (state == READ);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign start         = go && (state == IDLE || state == DONE);

`ifdef BLOCK_READER_SOF_SYNC_EN
  assign drop = accept && (cnt_q == '0) && !s_axis_tuser;
`else
  assign drop = 1'b0;
`endif

  assign pack = accept && !drop;

  // the LSB slice always holds the last pixel written, which is
  // also the last real pixel while replicate-padding
  assign pad_word = (PAD_MODE == 1) ? blk_q[DATA_WIDTH-1:0]
                                    : '0;

  always_comb begin
    state_nx = state;
    blk_d    = blk_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    sof_d    = sof_q;
    eol_d    = eol_q;
    unique case (state)
      IDLE, DONE: begin
        if (go) begin
          state_nx = READ;
          cnt_d    = '0;
          fill_d   = '0;
          sof_d    = 1'b0;
          eol_d    = 1'b0;
        end
      end
      READ: begin
        if (pack) begin
          blk_d  = {blk_q[BW-DATA_WIDTH-1:0], s_axis_tdata};
          cnt_d  = cnt_q + ONE;
          fill_d = fill_q + ONE;
          eol_d  = s_axis_tlast;
          if (cnt_q == '0) begin
            sof_d = s_axis_tuser;
          end
          if (cnt_q == LAST_IDX) begin
            state_nx = DONE;
          end else if (s_axis_tlast) begin
            state_nx = PAD;
          end
        end
      end
      PAD: begin
        blk_d  = {blk_q[BW-DATA_WIDTH-1:0], pad_word};
        fill_d = fill_q + ONE;
        if (fill_q == LAST_IDX) begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      blk_q  <= '0;
      cnt_q  <= '0;
      fill_q <= '0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      blk_q  <= blk_d;
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
      sof_q  <= sof_d;
      eol_q  <= eol_d;
    end
  end

`ifdef BLOCK_READER_SOF_SYNC_EN
  logic [15:0] drops_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drops_q <= '0;
    end else if (start) begin
      drops_q <= '0;
    end else if (drop && drops_q != 16'hFFFF) begin
      drops_q <= drops_q + 16'd1;
    end
  end

  assign sync_drops = drops_q;
`endif

  assign done        = (state == DONE);
  assign block       = blk_q;
  assign valid_count = cnt_q;
  assign sof         = sof_q;
  assign eol         = eol_q;

  logic unused_start;
  assign unused_start = start;

endmodule

// File: tb/tb_comperator_block_row_reader.sv
// Bench for comperator_block_row_reader: two instances (zero pad and
// replicate pad) share one stimulus stream; checks against a model.
module tb_comperator_block_row_reader;

  localparam int DW = 24;
  localparam int BS = 8;
  localparam int CW = 4;
  localparam int BW = BS * DW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          tuser = 1'b0;
  logic          go = 1'b0;

  logic          tready0, tready1;
  logic          done0, done1;
  logic [BW-1:0] block0, block1;
  logic [CW-1:0] vc0, vc1;
  logic          sof0, sof1;
  logic          eol0, eol1;
`ifdef BLOCK_READER_SOF_SYNC_EN
  logic [15:0]   drops0, drops1;
`endif

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] pix [BS];
  int pre_drops = 0;

  always #5 aclk = ~aclk;

  comperator_block_row_reader #(
    .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .PAD_MODE(0)
  ) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready0), .s_axis_tlast(tlast),
    .s_axis_tuser(tuser), .go(go), .done(done0),
    .block(block0), .valid_count(vc0), .sof(sof0), .eol(eol0)
`ifdef BLOCK_READER_SOF_SYNC_EN
    , .sync_drops(drops0)
`endif
  );

  comperator_block_row_reader #(
    .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .PAD_MODE(1)
  ) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready1), .s_axis_tlast(tlast),
    .s_axis_tuser(tuser), .go(go), .done(done1),
    .block(block1), .valid_count(vc1), .sof(sof1), .eol(eol1)
`ifdef BLOCK_READER_SOF_SYNC_EN
    , .sync_drops(drops1)
`endif
  );

  task automatic check(input string tag,
                       input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // n pixels from pix[], tlast on the n-th if last, tuser=u on first.
  // smode: 0 back-to-back, 1 one idle cycle between beats,
  // 2 random stalls with random go pulses (must be ignored).
  task automatic run_block(input int n, input bit last,
                           input bit u, input int smode);
    logic [BW-1:0] e0, e1;
    logic [DW-1:0] w0, w1;
    int lat, explat, ns;
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_done_low", BW'(done0), BW'(0));
    check("go_cnt_clr", BW'(vc0), BW'(0));
    check("go_sof_clr", BW'(sof0), BW'(0));
    check("go_eol_clr", BW'(eol0), BW'(0));
`ifdef BLOCK_READER_SOF_SYNC_EN
    check("go_drops_clr", BW'(drops0), BW'(0));
    for (int j = 0; j < pre_drops; j++) begin
      tvalid = 1'b1;
      tuser  = 1'b0;
      tdata  = DW'($urandom);
      tick();
    end
`endif
    for (int i = 0; i < n; i++) begin
      if (smode == 2) begin
        ns = $urandom_range(0, 2);
        for (int k = 0; k < ns; k++) begin
          tvalid = 1'b0;
          go     = 1'($urandom_range(0, 1));
          tdata  = DW'($urandom);
          tick();
          check("stall_tready", BW'(tready0), BW'(1));
        end
      end
      go     = 1'b0;
      tvalid = 1'b1;
      tdata  = pix[i];
      tuser  = (i == 0) ? u : 1'($urandom_range(0, 1));
      tlast  = (i == n - 1) ? last : 1'b0;
      check("beat_tready", BW'(tready0), BW'(1));
      tick();
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
      if (smode == 1 && i < n - 1) begin
        tick();
        check("toggle_tready", BW'(tready0), BW'(1));
      end
    end
    explat = (n == BS) ? 1 : BS - n + 1;
    lat = 1;
    while (done0 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", BW'(lat), BW'(explat));
    e0 = '0;
    e1 = '0;
    for (int w = 0; w < BS; w++) begin
      w0 = (w < n) ? pix[w] : '0;
      w1 = (w < n) ? pix[w] : pix[n-1];
      e0[(BS-1-w)*DW +: DW] = w0;
      e1[(BS-1-w)*DW +: DW] = w1;
    end
    check("block_zero_pad", block0, e0);
    check("block_rep_pad", block1, e1);
    check("valid_count0", BW'(vc0), BW'(n));
    check("valid_count1", BW'(vc1), BW'(n));
    check("sof", BW'(sof0), BW'(u));
    check("eol", BW'(eol0), BW'(last));
    check("done1", BW'(done1), BW'(1));
    check("done_tready", BW'(tready0), BW'(0));
`ifdef BLOCK_READER_SOF_SYNC_EN
    check("sync_drops", BW'(drops0), BW'(pre_drops));
`endif
    tvalid = 1'b1;
    repeat (3) tick();
    tvalid = 1'b0;
    check("hold_done", BW'(done0), BW'(1));
    check("hold_block", block0, e0);
    check("hold_count", BW'(vc0), BW'(n));
  endtask

  task automatic seq_pix();
    for (int i = 0; i < BS; i++) pix[i] = DW'(i + 1);
  endtask

  task automatic rand_pix();
    for (int i = 0; i < BS; i++) pix[i] = DW'($urandom);
  endtask

  initial begin
    int n;
    bit l, u;
    tick();
    check("rst_tready", BW'(tready0), BW'(0));
    check("rst_done", BW'(done0), BW'(0));
    check("rst_block", block0, '0);
    check("rst_count", BW'(vc0), BW'(0));
    check("rst_sof", BW'(sof0), BW'(0));
    check("rst_eol", BW'(eol0), BW'(0));
    aresetn = 1'b1;
    tick();

    seq_pix();
    run_block(8, 1'b0, 1'b1, 0);
    run_block(8, 1'b0, 1'b1, 1);

    pix[0] = 24'h00000A;
    pix[1] = 24'h00000B;
    pix[2] = 24'h00000C;
    run_block(3, 1'b1, 1'b1, 0);

    rand_pix();
    run_block(8, 1'b1, 1'b1, 0);

    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1;
      tdata  = DW'(24'hABC000 + i);
      tuser  = (i == 0);
      tick();
    end
    tvalid = 1'b0;
    tuser  = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_block", block0, '0);
    check("mid_rst_count", BW'(vc0), BW'(0));
    check("mid_rst_tready", BW'(tready0), BW'(0));
    check("mid_rst_done", BW'(done0), BW'(0));
    check("mid_rst_sof", BW'(sof0), BW'(0));
    tick();
    aresetn = 1'b1;
    tick();
    seq_pix();
    run_block(8, 1'b0, 1'b1, 0);

`ifdef BLOCK_READER_SOF_SYNC_EN
    pre_drops = 3;
    rand_pix();
    run_block(8, 1'b0, 1'b1, 0);
    pre_drops = 0;
`endif

    repeat (30) begin
      n = $urandom_range(1, BS);
      l = (n < BS) ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef BLOCK_READER_SOF_SYNC_EN
      u = 1'b1;
`else
      u = 1'($urandom_range(0, 1));
`endif
      rand_pix();
      run_block(n, l, u, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comperator_block_row_reader.md
Name: comperator_block_row_reader

Overview:
- Parametrised successor of the single-row pixel block reader in the stereoscopic comparator IP.
- On a go request, accepts up to BLOCK_SIZE pixels from an AXI4-Stream video input and packs them into one flat block register.
- Pads short blocks that end early on tlast, and reports fill count, start-of-frame and end-of-line status to the comparator core.

Parameters:
- DATA_WIDTH, 24, pixel width in bits (tdata width).
- BLOCK_SIZE, 8, pixels per block, minimum 2.
- PAD_MODE, 0, 0 = pad with zeros, 1 = replicate last accepted pixel.
- CNT_W, $clog2(BLOCK_SIZE+1), width of the fill counter.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  pixel data.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accept.
- s_axis_tlast  in  1  end of video line.
- s_axis_tuser  in  1  start of frame.
- go  in  1  start one block read; ignored unless state is IDLE or DONE.
- done  out  1  block complete; level, held until next go.
- block  out  BLOCK_SIZE*DATA_WIDTH  packed pixels; first pixel in the MSB slice, last pixel in the LSB slice.
- valid_count  out  CNT_W  real (non-pad) pixels in block, 1..BLOCK_SIZE.
- sof  out  1  tuser was set on the first accepted beat of this block.
- eol  out  1  tlast was set on the last accepted beat of this block.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE.
  - s_axis_tready, done, sof, eol = 0.
  - block, valid_count = 0.
  - Reset mid-read abandons the block; no partial done is ever raised.
- Beat acceptance: a beat is accepted when s_axis_tvalid && s_axis_tready. s_axis_tready = (state==READ), driven combinationally from the state register.
- IDLE: on go, go to READ; clear count, sof and eol. done stays 0.
- READ, per accepted beat:
  - block <= {block[upper], tdata}, i.e. shift left by DATA_WIDTH.
  - count increments.
  - On the first beat (count==0), sof <= tuser.
  - eol <= tlast.
  - Beats with tvalid=0 hold all state (any stall length).
- READ exit conditions:
  - Accepted beat with count==BLOCK_SIZE-1: go to DONE next cycle.
  - Accepted beat with tlast=1 and count<BLOCK_SIZE-1: go to PAD.
  - If both hold on the same beat, go to DONE and set eol=1.
- PAD:
  - tready=0.
  - Each cycle shifts in one pad word (zero, or the last pixel if PAD_MODE=1) until BLOCK_SIZE words total, then goes to DONE.
  - Padding takes BLOCK_SIZE-valid_count cycles.
  - valid_count is not incremented by pad words.
- DONE:
  - done=1; block, valid_count, sof and eol are stable.
  - go returns to READ; done drops the next cycle and the outputs clear as in IDLE.
- go in READ or PAD has no effect.
- Latency:
  - Full block: done rises 1 cycle after the BLOCK_SIZE-th accepted beat.
  - Short block of n pixels: done rises BLOCK_SIZE-n+1 cycles after the tlast beat.
- The count register is CNT_W bits wide and never wraps, because it saturates at BLOCK_SIZE via the state exit.

Optional Feature:
- Macro: BLOCK_READER_SOF_SYNC_EN.
- When defined:
  - After go, in READ with count==0, accepted beats with tuser=0 are consumed and discarded: tready stays 1, block and count are unchanged.
  - Packing starts at the first beat with tuser=1, so sof is always 1.
  - An extra output sync_drops (16 bits, saturating, reset 0, cleared on go) counts the discarded beats.
- When undefined: no discard; sof reflects the first beat as described; no sync_drops port.

Test Plan:
- BLOCK_SIZE=8, DATA_WIDTH=24:
  - Eight back-to-back beats 0x000001..0x000008, tuser on the first beat, no tlast -> done one cycle after the last beat.
  - block = 0x000001_000002_…_000008 (first pixel MSB), valid_count=8, sof=1, eol=0.
- Same stream with tvalid toggled 1-0-1-0 -> identical block; tready high only in READ; done delayed by exactly the stall cycles.
- Three beats 0xA, 0xB, 0xC with tlast on 0xC:
  - PAD_MODE=0 -> block = A,B,C followed by five zero words; valid_count=3, eol=1; done 6 cycles after the tlast beat.
  - PAD_MODE=1 -> the five pad words are 0xC.
- tlast on the 8th beat -> no PAD state; done next cycle; eol=1, valid_count=8.
- aresetn pulsed low after 4 beats -> all outputs 0 immediately; a following go and 8 beats produce a clean block with no residue.
- With BLOCK_READER_SOF_SYNC_EN: three tuser=0 beats, then 8 beats starting with tuser=1 -> sync_drops=3, block holds only the 8 later beats, sof=1.
